// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single request/grant/valid memory port between the core's
//   instruction-fetch port and its data port. Each accepted request pushes
//   the issuing port's ID into an in-order FIFO. Each memory response pops
//   that FIFO and is steered, with no added latency, back to the port that
//   issued the request.
//
//   Ports
//     clk_i, arst_i                  clock, asynchronous active-high reset
//     inst_req_i / inst_addr_i       fetch request (held until granted)
//     inst_grnt_o                    fetch request accepted this cycle
//     inst_data_o / inst_valid_o     fetch response
//     data_req_i / data_addr_i /
//     data_wdata_i / data_wen_i      load/store request (held until granted)
//     data_grnt_o                    data request accepted this cycle
//     data_rdata_o / data_valid_o    load data or store acknowledge
//     mem_req_o / mem_addr_o /
//     mem_wdata_o / mem_wen_o        request to memory
//     mem_grnt_i                     memory accepted the request
//     mem_rdata_i / mem_valid_i      memory response, in order
//     err_o                          sticky: response with nothing outstanding
//
//   Optional build macro MEM_ARB_PERF_CNT_EN adds three 32-bit wrapping
//   counters: perf_inst_grants_o, perf_data_grants_o, perf_full_stall_o.
//
//   FSM states
//     state     | meaning
//     ST_IDLE   | pick a winner each cycle if the FIFO has room
//     ST_LOCKED | request presented but not granted; hold the same winner

module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk_i,
  input  logic              arst_i,

  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_grnt_o,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              inst_valid_o,

  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic              data_wen_i,
  output logic              data_grnt_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_valid_o,

  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wen_o,
  input  logic              mem_grnt_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_valid_i,

  output logic              err_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_inst_grants_o,
  output logic [31:0]       perf_data_grants_o,
  output logic [31:0]       perf_full_stall_o
`endif
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             winner_q, winner_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             err_q;

  logic             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             sel;
  logic             req;
  logic             xfer;
  logic             pop;
  logic             head_id;
  logic             full;
  logic             any_req;

  assign full    = (count_q == FULL_CNT);
  assign any_req = inst_req_i | data_req_i;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    sel      = ID_DATA;
    req      = 1'b0;
    if (state_q == ST_LOCKED) begin
      // The winner is frozen until memory takes it, whatever the other port does.
      req = 1'b1;
      sel = winner_q;
      if (mem_grnt_i) begin
        state_d = ST_IDLE;
      end
    end else begin
      sel = (inst_req_i && (!data_req_i || (starve_q == STARVE_MAX))) ? ID_INST : ID_DATA;
      // Full is judged on the registered count, so a pop this cycle only
      // frees a slot from the next cycle onward.
      req = any_req && !full;
      if (req && !mem_grnt_i) begin
        state_d  = ST_LOCKED;
        winner_d = sel;
      end
    end
    if (arst_i) begin
      req = 1'b0;
    end
  end

  assign xfer        = req & mem_grnt_i;
  assign mem_req_o   = req;
  assign mem_addr_o  = !req ? '0 : ((sel == ID_DATA) ? data_addr_i : inst_addr_i);
  assign mem_wdata_o = (req && (sel == ID_DATA)) ? data_wdata_i : '0;
  assign mem_wen_o   = req && (sel == ID_DATA) && data_wen_i;
  assign inst_grnt_o = xfer && (sel == ID_INST);
  assign data_grnt_o = xfer && (sel == ID_DATA);

  // Responses with nothing outstanding are dropped here and only flagged.
  assign pop          = mem_valid_i && (count_q != '0) && !arst_i;
  assign head_id      = fifo_q[rd_ptr_q];
  assign inst_valid_o = pop && (head_id == ID_INST);
  assign data_valid_o = pop && (head_id == ID_DATA);
  assign inst_data_o  = inst_valid_o ? mem_rdata_i : '0;
  assign data_rdata_o = data_valid_o ? mem_rdata_i : '0;
  assign err_o        = err_q;

  always_comb begin
    starve_d = starve_q;
    if (!inst_req_i || inst_grnt_o) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      winner_q <= ID_INST;
      starve_q <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      starve_q <= starve_d;
      if (xfer) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (xfer && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !xfer) begin
        count_q <= count_q - 1'b1;
      end
      if (mem_valid_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_inst_q, perf_data_q, perf_stall_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      perf_inst_q  <= '0;
      perf_data_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (inst_grnt_o) begin
        perf_inst_q <= perf_inst_q + 32'd1;
      end
      if (data_grnt_o) begin
        perf_data_q <= perf_data_q + 32'd1;
      end
      if (any_req && full) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_inst_grants_o = perf_inst_q;
  assign perf_data_grants_o = perf_data_q;
  assign perf_full_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;
  localparam int STARVE  = 8;

  logic              clk_i = 1'b0;
  logic              arst_i;
  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_grnt_o;
  logic [DATA_W-1:0] inst_data_o;
  logic              inst_valid_o;
  logic              data_req_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_wen_i;
  logic              data_grnt_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_valid_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_wen_o;
  logic              mem_grnt_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_valid_i;
  logic              err_o;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]       perf_inst_grants_o;
  logic [31:0]       perf_data_grants_o;
  logic [31:0]       perf_full_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_grnt_o(inst_grnt_o),
    .inst_data_o(inst_data_o), .inst_valid_o(inst_valid_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_wen_i(data_wen_i), .data_grnt_o(data_grnt_o), .data_rdata_o(data_rdata_o),
    .data_valid_o(data_valid_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wen_o(mem_wen_o), .mem_grnt_i(mem_grnt_i), .mem_rdata_i(mem_rdata_i),
    .mem_valid_i(mem_valid_i), .err_o(err_o)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_inst_grants_o(perf_inst_grants_o),
    .perf_data_grants_o(perf_data_grants_o),
    .perf_full_stall_o(perf_full_stall_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    n_checks++;
    $display("FAIL %s: event occurred, required none", name);
  endfunction

  // Memory contents never written hold a fixed pattern derived from the address.
  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory model (responds to the DUT) and reference model (expected results).
  typedef struct { logic [31:0] rdata; int due; } resp_t;
  typedef struct { bit st; logic [31:0] val; } dexp_t;

  resp_t       pend[$];
  logic [31:0] memm [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  logic [31:0] inst_exp[$];
  dexp_t       data_exp[$];
  int          grant_log[$];

  int inst_mode = 0, data_mode = 0, grant_pct = 100, lat_min = 1, lat_max = 1, cyc = 0;
  bit hold = 0, auto_stim = 0, stray = 0;
  logic obs_req, obs_ig, obs_dg, obs_vld;
  logic [31:0] obs_addr;
  int n_iv = 0, n_dv = 0;

  function automatic logic [31:0] mem_read(logic [31:0] a);
    return memm.exists(a) ? memm[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  task automatic issue_inst(logic [31:0] a);
    inst_req_i  = 1'b1;
    inst_addr_i = a;
    inst_exp.push_back(init_val(a));
  endtask

  task automatic issue_data(logic [31:0] a, logic we, logic [31:0] wd);
    dexp_t e;
    data_req_i   = 1'b1;
    data_addr_i  = a;
    data_wen_i   = we;
    data_wdata_i = wd;
    e.st  = we;
    e.val = ref_read(a);
    if (we) refm[a] = wd;
    data_exp.push_back(e);
  endtask

  task automatic step();
    @(negedge clk_i);
    obs_req  = mem_req_o;
    obs_addr = mem_addr_o;
    obs_ig   = inst_grnt_o;
    obs_dg   = data_grnt_o;
    obs_vld  = mem_valid_i;
    if (mem_req_o && mem_grnt_i && !arst_i) begin
      resp_t r;
      if (mem_wen_o) begin
        memm[mem_addr_o] = mem_wdata_o;
        r.rdata = $urandom;
      end else begin
        r.rdata = mem_read(mem_addr_o);
      end
      r.due = cyc + $urandom_range(lat_min, lat_max);
      pend.push_back(r);
    end
    if (obs_ig) grant_log.push_back(0);
    if (obs_dg) grant_log.push_back(1);
    @(posedge clk_i);
    #1;
    cyc++;
    mem_valid_i = 1'b0;
    mem_rdata_i = $urandom;
    if (stray) begin
      mem_valid_i = 1'b1;
      stray = 0;
    end else if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_valid_i = 1'b1;
      mem_rdata_i = pend[0].rdata;
      void'(pend.pop_front());
    end
    mem_grnt_i = ($urandom_range(1, 100) <= grant_pct);
    if (auto_stim) begin
      if (!(inst_req_i && !obs_ig)) begin
        if (inst_mode == 2 || (inst_mode == 1 && $urandom_range(0, 1) == 1))
          issue_inst(32'h1000 + (32'($urandom_range(0, 255)) << 2));
        else
          inst_req_i = 1'b0;
      end
      if (!(data_req_i && !obs_dg)) begin
        if (data_mode == 2 || (data_mode == 1 && $urandom_range(0, 1) == 1))
          issue_data(32'h100 + (32'($urandom_range(0, 15)) << 2),
                     1'($urandom_range(0, 1)), $urandom);
        else
          data_req_i = 1'b0;
      end
    end
  endtask

  task automatic drain();
    auto_stim = 1; inst_mode = 0; data_mode = 0; hold = 0; grant_pct = 100;
    for (int i = 0; i < 300; i++) begin
      if (!inst_req_i && !data_req_i && pend.size() == 0 &&
          inst_exp.size() == 0 && data_exp.size() == 0) break;
      step();
    end
    chk("drain_inst_pending", 64'(inst_exp.size()), 0);
    chk("drain_data_pending", 64'(data_exp.size()), 0);
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk_i) begin
    if (inst_valid_o || data_valid_o)
      chk("single_valid", 64'(inst_valid_o & data_valid_o), 0);
    if (inst_valid_o) begin
      n_iv++;
      if (inst_exp.size() == 0) fail("inst_valid_unexpected");
      else chk("inst_rdata", 64'(inst_data_o), 64'(inst_exp.pop_front()));
    end
    if (data_valid_o) begin
      n_dv++;
      if (data_exp.size() == 0) fail("data_valid_unexpected");
      else begin
        dexp_t e;
        e = data_exp.pop_front();
        if (!e.st) chk("data_rdata", 64'(data_rdata_o), 64'(e.val));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int iv0, dv0, t;
    arst_i = 1'b1;
    inst_req_i = 1'b1; inst_addr_i = 32'h40; data_req_i = 1'b1; data_addr_i = 32'h80;
    data_wdata_i = 32'h1234; data_wen_i = 1'b1;
    mem_grnt_i = 1'b1; mem_rdata_i = 32'hDEAD; mem_valid_i = 1'b1;

    // Reset values with every input active.
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req",    64'(mem_req_o), 0);
    chk("rst_mem_addr",   64'(mem_addr_o), 0);
    chk("rst_mem_wdata",  64'(mem_wdata_o), 0);
    chk("rst_mem_wen",    64'(mem_wen_o), 0);
    chk("rst_inst_grnt",  64'(inst_grnt_o), 0);
    chk("rst_data_grnt",  64'(data_grnt_o), 0);
    chk("rst_inst_valid", 64'(inst_valid_o), 0);
    chk("rst_data_valid", 64'(data_valid_o), 0);
    chk("rst_inst_data",  64'(inst_data_o), 0);
    chk("rst_err",        64'(err_o), 0);
    inst_req_i = 1'b0; data_req_i = 1'b0; data_wen_i = 1'b0; mem_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;

    // Fetch only, addresses 0x0/0x4/0x8, immediate grant, 1-cycle response.
    iv0 = n_iv; dv0 = n_dv;
    for (int k = 0; k < 3; k++) begin
      issue_inst(32'(k * 4));
      t = 0;
      do begin step(); t++; end while (!obs_ig && t < 20);
      if (!obs_ig) fail("fetch_grant_timeout");
    end
    inst_req_i = 1'b0;
    repeat (4) step();
    chk("fetch_valid_count", 64'(n_iv - iv0), 3);
    chk("fetch_no_data_valid", 64'(n_dv - dv0), 0);

    // Grant withheld 3 cycles with fetch selected; data arrives in cycle 2.
    grant_pct = 0;
    step();
    issue_inst(32'h2000);
    step();
    chk("lock_c1_req", 64'(obs_req), 1);
    chk("lock_c1_addr", 64'(obs_addr), 64'h2000);
    issue_data(32'h104, 1'b0, 32'h0);
    step();
    chk("lock_c2_addr", 64'(obs_addr), 64'h2000);
    chk("lock_c2_dgrnt", 64'(obs_dg), 0);
    grant_pct = 100;
    step();
    chk("lock_c3_addr", 64'(obs_addr), 64'h2000);
    step();
    chk("lock_inst_grant", 64'(obs_ig), 1);
    chk("lock_inst_grant_addr", 64'(obs_addr), 64'h2000);
    chk("lock_no_data_grant", 64'(obs_dg), 0);
    inst_req_i = 1'b0;
    step();
    chk("lock_data_after", 64'(obs_dg), 1);
    chk("lock_data_addr", 64'(obs_addr), 64'h104);
    data_req_i = 1'b0;
    drain();

    // Both ports requesting continuously: 8 data grants, then one fetch.
    lat_min = 1; lat_max = 1; grant_pct = 100;
    grant_log.delete();
    auto_stim = 1; inst_mode = 2; data_mode = 2;
    repeat (30) step();
    if (grant_log.size() < 18) fail("starve_too_few_grants");
    else for (int i = 0; i < 18; i++)
      chk($sformatf("starve_grant_%0d", i), 64'(grant_log[i]), (i % 9 == 8) ? 0 : 1);
    drain();

    // FIFO full: four transfers, then no request until a response frees a slot.
    grant_log.delete();
    hold = 1; data_mode = 2; inst_mode = 0;
    repeat (10) step();
    chk("full_accepts", 64'(grant_log.size()), 4);
    chk("full_req_low", 64'(obs_req), 0);
    hold = 0;
    step();
    step();
    chk("full_pop_cycle_vld", 64'(obs_vld), 1);
    chk("full_pop_cycle_req", 64'(obs_req), 0);
    step();
    chk("full_resume_req", 64'(obs_req), 1);
    drain();

    // Randomized traffic, then fixed 5-cycle response latency.
    auto_stim = 1; inst_mode = 1; data_mode = 1; grant_pct = 70; lat_min = 1; lat_max = 6;
    repeat (800) step();
    drain();
    auto_stim = 1; inst_mode = 1; data_mode = 1; grant_pct = 100; lat_min = 5; lat_max = 5;
    repeat (200) step();
    drain();
    lat_min = 1; lat_max = 1;

    // Reset with fetches in flight: stale responses are dropped and flag err_o.
    hold = 1; inst_mode = 2; data_mode = 0;
    repeat (6) step();
    auto_stim = 0; inst_req_i = 1'b0;
    arst_i = 1'b1;
    inst_exp.delete(); data_exp.delete();
    step();
    chk("rst_mid_req", 64'(obs_req), 0);
    arst_i = 1'b0; hold = 0;
    for (int i = 0; i < 20 && pend.size() > 0; i++) step();
    step();
    chk("stale_resp_err", 64'(err_o), 1);
    arst_i = 1'b1;
    step();
    arst_i = 1'b0;
    step();
    chk("err_cleared", 64'(err_o), 0);

    // Stray response with nothing outstanding.
    stray = 1;
    step();
    step();
    step();
    chk("stray_err_set", 64'(err_o), 1);
    repeat (3) step();
    chk("stray_err_sticky", 64'(err_o), 1);
    arst_i = 1'b1;
    step();
    arst_i = 1'b0;
    step();
    chk("stray_err_reset", 64'(err_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port request/grant/valid memory between the core's instruction-fetch port and data port.
- Arbitrates each request, tracks up to MAX_OUTSTANDING in-flight transactions in an in-order ID FIFO, and routes each response back to the port that issued it.
- Sits between the core and the unified memory model in the emulator harness.

Parameters:
- ADDR_W, 32, address width of both ports and the memory side.
- DATA_W, 32, data width.
- MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO; power of two, at least 2.
- STARVE_LIMIT, 8, consecutive lost-arbitration cycles before instruction fetch is forced to win.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous active-high reset.
- inst_req_i  in  1  fetch request; held with its address until granted.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_grnt_o  out  1  fetch request accepted this cycle.
- inst_data_o  out  DATA_W  fetch read data.
- inst_valid_o  out  1  fetch response valid.
- data_req_i  in  1  load/store request; held with its payload until granted.
- data_addr_i  in  ADDR_W  load/store address.
- data_wdata_i  in  DATA_W  store data.
- data_wen_i  in  1  1 = store, 0 = load.
- data_grnt_o  out  1  data request accepted this cycle.
- data_rdata_o  out  DATA_W  load data; undefined on store acks.
- data_valid_o  out  1  data response valid (load data or store ack).
- mem_req_o  out  1  request to memory.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_wen_o  out  1  memory write enable.
- mem_grnt_i  in  1  memory accepted the request.
- mem_rdata_i  in  DATA_W  memory response data.
- mem_valid_i  in  1  memory response; exactly one per accepted request, in order.
- err_o  out  1  sticky: a response arrived with no transaction outstanding.

Behaviour:
- Reset values: all grant, valid and request outputs 0; data, address and write-data outputs 0; err_o 0. FIFO empty, lock cleared, starvation counter 0.
- A transfer occurs when mem_req_o and mem_grnt_i are both high in the same cycle. The selected port's grant output equals mem_grnt_i that cycle (combinational); the other port's grant is 0.
- State machine, two states:
  - IDLE: if the registered outstanding count is below MAX_OUTSTANDING and any request is present, select a winner and drive mem_req_o in the same cycle. If not granted, register the winner and go to LOCKED.
  - LOCKED: mem_req_o stays high for the registered winner regardless of the other port's requests. On mem_grnt_i, return to IDLE.
  - A requester dropping its request while LOCKED is a protocol violation; behaviour is undefined.
- Priority in IDLE: data wins by default. Instruction fetch wins when the starvation counter equals STARVE_LIMIT.
  - The counter increments on every cycle inst_req_i is high but fetch is not granted, saturating at STARVE_LIMIT.
  - It clears on a fetch grant, and also when inst_req_i is low.
- Full condition: when the registered count equals MAX_OUTSTANDING, mem_req_o is 0 in IDLE. A same-cycle response pop does not unblock issue; issue resumes the next cycle.
- Push/pop:
  - Each transfer pushes the winner ID (0 = inst, 1 = data) into the FIFO.
  - Each mem_valid_i pops the head ID and steers mem_rdata_i, combinationally and zero-latency, to inst_data_o/inst_valid_o or data_rdata_o/data_valid_o.
  - Simultaneous push and pop in one cycle leaves the count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Best-case request-to-response latency equals memory latency; the arbiter adds no cycles.
- mem_valid_i with the FIFO empty: the response is dropped, no valid output is driven, and err_o is set until reset.
- Reset mid-operation clears the FIFO and lock. Responses arriving after reset for pre-reset transactions are dropped and set err_o.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, three 32-bit wrapping output ports are added, each cleared by reset:
  - perf_inst_grants_o: fetch transfers.
  - perf_data_grants_o: data transfers.
  - perf_full_stall_o: cycles with any request present while the FIFO is full.
- When undefined, these ports and their registers do not exist.

Test Plan:
- Fetch only, memory grants immediately, 1-cycle response, addresses 0x0/0x4/0x8 → three inst_valid_o pulses with matching data; data_valid_o never high.
- Both ports request continuously, STARVE_LIMIT=8 → data granted 8 consecutive times, then fetch granted once, then the pattern repeats.
- mem_grnt_i held low for 3 cycles with fetch selected, data_req_i rising in cycle 2 → mem_addr_o stays at the fetch address until grant, and data is granted afterwards.
- Interleaved inst/data/inst transfers, responses returned 5 cycles later → valids routed inst, data, inst in order; a data store returns data_valid_o as its ack.
- MAX_OUTSTANDING=4, memory withholds responses → 4 transfers accepted, then mem_req_o stays 0; the first response lets a request issue on the following cycle.
- mem_valid_i pulsed with no transaction outstanding, then arst_i pulsed → err_o goes high and stays high until reset, then reads 0.
